// File: rtl/sequence_detector_1101.sv
// Moore detector for the serial pattern 1101 (first bit first) with overlap.
// W is decoded from the current state only and pulses for one cycle per match.
module sequence_detector_1101 (
  input  logic Clk,
  input  logic Rst,
  input  logic J,
  output logic W
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // nothing matched
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101" detected
  } state_t;

  state_t state;
  state_t next_state;

  // State register with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; from S4 the trailing "1" is retained so overlaps are found.
  always_comb begin
    next_state = S0;
    case (state)
      S0: begin
        if (J) next_state = S1;
        else   next_state = S0;
      end
      S1: begin
        if (J) next_state = S2;
        else   next_state = S0;
      end
      S2: begin
        if (J) next_state = S2;
        else   next_state = S3;
      end
      S3: begin
        if (J) next_state = S4;
        else   next_state = S0;
      end
      S4: begin
        if (J) next_state = S2;
        else   next_state = S0;
      end
      default: next_state = S0;
    endcase
  end

  // Output decode from the current state only.
  always_comb begin
    W = 1'b0;
    case (state)
      S4:      W = 1'b1;
      default: W = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sequence_detector_1101.sv
// Self-checking bench for sequence_detector_1101: directed spec scenarios,
// asynchronous reset behaviour and a randomized stream against a pattern model.
module tb_sequence_detector_1101;

  logic Clk;
  logic Rst;
  logic J;
  logic W;

  int total;
  int bad;

  // Bits sampled since the last reset; a match is the last four being 1,1,0,1.
  bit hist[$];

  sequence_detector_1101 dut (
    .Clk(Clk),
    .Rst(Rst),
    .J  (J),
    .W  (W)
  );

  initial Clk = 1'b0;
  always #100 Clk = ~Clk;

  function automatic logic model_match();
    int n;
    n = hist.size();
    if (n < 4) return 1'b0;
    return (hist[n-4] == 1'b1) && (hist[n-3] == 1'b1) &&
           (hist[n-2] == 1'b0) && (hist[n-1] == 1'b1);
  endfunction

  // Drive one bit 10 ns before the rising edge, return 1 ns after it with the model updated.
  task automatic send_bit(input logic b, output logic exp);
    @(negedge Clk);
    #90;
    J = b;
    @(posedge Clk);
    hist.push_back(b);
    #1;
    exp = model_match();
  endtask

  task automatic test_reset();
    logic e;
    #50;
    Rst = 1'b1;
    #1;
    total++;
    if (W !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: W=%b expected 0", W);
    end
    hist.delete();
    // Held reset: random J over several edges must never produce W.
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      #90;
      J = (i % 3 != 2) ? 1'b1 : 1'b0;
      @(posedge Clk);
      #1;
      total++;
      if (W !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: edge %0d W=%b expected 0", i, W);
      end
    end
    @(negedge Clk);
    Rst = 1'b0;
    hist.delete();
    e = 1'b0;
  endtask

  task automatic test_stream();
    logic bits [13];
    logic e;
    logic exp_spec;
    bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 20; i++) begin
      send_bit((i < 13) ? bits[i] : 1'b1, e);
      exp_spec = (i == 10) ? 1'b1 : 1'b0;
      total++;
      if (W !== exp_spec || e !== exp_spec) begin
        bad++;
        $display("FAIL stream: bit %0d W=%b model=%b expected %b", i + 1, W, e, exp_spec);
      end
    end
  endtask

  task automatic test_overlap();
    logic bits [7];
    logic e;
    logic exp_spec;
    bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send_bit(1'b0, e);
    send_bit(1'b0, e);
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[i], e);
      exp_spec = (i == 3 || i == 6) ? 1'b1 : 1'b0;
      total++;
      if (W !== exp_spec) begin
        bad++;
        $display("FAIL overlap: bit %0d W=%b expected %b", i + 1, W, exp_spec);
      end
    end
  endtask

  task automatic test_constant();
    logic e;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 20; i++) begin
        send_bit(v[0], e);
        total++;
        if (W !== 1'b0) begin
          bad++;
          $display("FAIL constant_%0d: edge %0d W=%b expected 0", v, i, W);
        end
      end
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic e;
    int pulses;
    send_bit(1'b0, e);
    send_bit(1'b1, e);
    send_bit(1'b1, e);
    send_bit(1'b0, e);
    #50;
    Rst = 1'b1;
    #1;
    total++;
    if (W !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_w: W=%b expected 0", W);
    end
    #20;
    Rst = 1'b0;
    hist.delete();
    send_bit(1'b1, e);
    total++;
    if (W !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_match: W=%b expected 0", W);
    end
    pulses = 0;
    send_bit(1'b1, e); pulses += int'(W);
    send_bit(1'b0, e); pulses += int'(W);
    send_bit(1'b1, e); pulses += int'(W);
    total++;
    if (W !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_rematch: W=%b expected 1", W);
    end
    send_bit(1'b0, e); pulses += int'(W);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL mid_reset_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_reset_during_detect();
    logic e;
    send_bit(1'b1, e);
    send_bit(1'b1, e);
    send_bit(1'b0, e);
    send_bit(1'b1, e);
    total++;
    if (W !== 1'b1) begin
      bad++;
      $display("FAIL detect_before_reset: W=%b expected 1", W);
    end
    #20;
    Rst = 1'b1;
    #1;
    total++;
    if (W !== 1'b0) begin
      bad++;
      $display("FAIL reset_kills_w: W=%b expected 0", W);
    end
    #20;
    Rst = 1'b0;
    hist.delete();
  endtask

  task automatic test_leading_ones();
    logic bits [6];
    logic e;
    logic exp_spec;
    bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    send_bit(1'b0, e);
    for (int i = 0; i < 6; i++) begin
      send_bit(bits[i], e);
      exp_spec = (i == 5) ? 1'b1 : 1'b0;
      total++;
      if (W !== exp_spec) begin
        bad++;
        $display("FAIL leading_ones: bit %0d W=%b expected %b", i + 1, W, exp_spec);
      end
    end
  endtask

  task automatic test_random();
    logic e;
    int last_pulse;
    last_pulse = -10;
    for (int i = 0; i < 400; i++) begin
      send_bit(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, e);
      total++;
      if (W !== e) begin
        bad++;
        $display("FAIL random: step %0d W=%b expected %b", i, W, e);
      end
      if (W === 1'b1) begin
        total++;
        if (i - last_pulse < 3) begin
          bad++;
          $display("FAIL pulse_spacing: step %0d gap %0d expected >=3", i, i - last_pulse);
        end
        last_pulse = i;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b0;
    J     = 1'b0;
    test_reset();
    test_stream();
    test_overlap();
    test_constant();
    test_reset_mid_pattern();
    test_reset_during_detect();
    test_leading_ones();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
